frame_mem_bist: RTL and testbench

//  Parametrised frame-buffer memory self-test engine on one Avalon-style RAM port of ram_int_4p.

---
 rtl/frame_bist_pkg.sv | 27 ++
 rtl/bist_pattern_gen.sv | 61 ++++++
 rtl/frame_mem_bist.sv | 251 +++++++++++++++++++++++++
 tb/tb_frame_mem_bist.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_bist_pkg.sv
// rtl/frame_bist_pkg.sv - shared types and constants for the frame memory self-test
package frame_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        MODE_CONST = 2'd0,
        MODE_ADDR  = 2'd1,
        MODE_NADDR = 2'd2,
        MODE_LFSR  = 2'd3
    } mode_e;

    // Right-shifting Galois form of x^32+x^22+x^2+x+1
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/bist_pattern_gen.sv
// rtl/bist_pattern_gen.sv - test pattern source for one word index (write side or expected side)
// FRAME_BIST_LFSR_EN adds the LFSR pattern; without it mode 3 falls back to the constant.
module bist_pattern_gen
    import frame_bist_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                IDX_W      = 19,
    parameter logic [DATA_W-1:0] PATT_CONST = 32'h00FF_FFFF,
    parameter logic [31:0]       LFSR_SEED  = 32'hACE1_2468
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic [IDX_W-1:0]  idx,
    input  logic              step,
    input  logic              seed_load,
    output logic [DATA_W-1:0] pattern
);

    logic [DATA_W-1:0] lfsr_word;

`ifdef FRAME_BIST_LFSR_EN
    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (seed_load) begin
            lfsr_d = LFSR_SEED;
        end else if (step) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_word = lfsr_q[DATA_W-1:0];
`else
    logic unused_lfsr_in;
    assign unused_lfsr_in = ^{clk, reset, step, seed_load, LFSR_SEED};
    assign lfsr_word      = PATT_CONST;
`endif

    always_comb begin
        pattern = PATT_CONST;
        case (mode)
            MODE_CONST: pattern = PATT_CONST;
            MODE_ADDR:  pattern = DATA_W'(idx);
            MODE_NADDR: pattern = ~(DATA_W'(idx));
            MODE_LFSR:  pattern = lfsr_word;
            default:    pattern = PATT_CONST;
        endcase
    end

endmodule

// File: rtl/frame_mem_bist.sv
// rtl/frame_mem_bist.sv - write/read-back self-test of a frame buffer over one Avalon-style port
// Optional FRAME_BIST_LFSR_EN enables the LFSR pattern (mode 3).
module frame_mem_bist
    import frame_bist_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 29,
    parameter int                CMP_W      = 24,
    parameter int                FRAME_PIX  = 307200,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter logic [DATA_W-1:0] PATT_CONST = 32'h00FF_FFFF,
    parameter logic [31:0]       LFSR_SEED  = 32'hACE1_2468,
    parameter int                WDOG_CYC   = 1048576
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              ram_rdy,
    input  logic              avl_ready,
    output logic              avl_write_req,
    output logic              avl_read_req,
    output logic [ADDR_W-1:0] avl_addr,
    output logic [DATA_W-1:0] avl_wdata,
    input  logic [DATA_W-1:0] avl_rdata,
    input  logic              avl_rdata_valid,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              timeout
);

    localparam int               IDX_W     = $clog2(FRAME_PIX + 1);
    localparam int               WD_W      = $clog2(WDOG_CYC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_PIX - 1);
    localparam logic [IDX_W-1:0] FRAME_CNT = IDX_W'(FRAME_PIX);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(WDOG_CYC - 1);

    state_e              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [IDX_W-1:0]    req_idx_q, req_idx_d;
    logic [IDX_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic                wr_req_q, wr_req_d;
    logic                rd_req_q, rd_req_d;
    logic                busy_q, busy_d;
    logic                pass_q, pass_d;
    logic                fail_q, fail_d;
    logic [15:0]         err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]   first_err_addr_q, first_err_addr_d;
    logic                timeout_q, timeout_d;
    logic [WD_W-1:0]     wdog_q, wdog_d;
    logic                armed_q, armed_d;
    logic                chk_mis_q, chk_mis_d;
    logic                chk_stray_q, chk_stray_d;
    logic [ADDR_W-1:0]   chk_addr_q, chk_addr_d;

    logic                wr_seed, rd_seed;
    logic [DATA_W-1:0]   wr_pat, exp_pat;
    logic                wr_acc, rd_acc, activity, active, rd_open, exp_step, stray;

    assign wr_acc   = wr_req_q & avl_ready;
    assign rd_acc   = rd_req_q & avl_ready;
    assign activity = wr_acc | rd_acc | avl_rdata_valid;
    assign active   = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign rd_open  = ((state_q == ST_READ) || (state_q == ST_DRAIN)) && (rd_cnt_q != FRAME_CNT);
    assign exp_step = avl_rdata_valid & rd_open;
    // Returns still in flight after a reset land in IDLE with armed_q clear and are dropped.
    assign stray    = avl_rdata_valid & ~rd_open & ((state_q != ST_IDLE) | armed_q);

    bist_pattern_gen #(
        .DATA_W(DATA_W), .IDX_W(IDX_W), .PATT_CONST(PATT_CONST), .LFSR_SEED(LFSR_SEED)
    ) u_wr_gen (
        .clk(clk), .reset(reset), .mode(mode_q), .idx(req_idx_q),
        .step(wr_acc), .seed_load(wr_seed), .pattern(wr_pat)
    );

    bist_pattern_gen #(
        .DATA_W(DATA_W), .IDX_W(IDX_W), .PATT_CONST(PATT_CONST), .LFSR_SEED(LFSR_SEED)
    ) u_exp_gen (
        .clk(clk), .reset(reset), .mode(mode_q), .idx(rd_cnt_q),
        .step(exp_step), .seed_load(rd_seed), .pattern(exp_pat)
    );

    always_comb begin
        state_d          = state_q;
        mode_d           = mode_q;
        req_idx_d        = req_idx_q;
        rd_cnt_d         = rd_cnt_q;
        wr_req_d         = wr_req_q;
        rd_req_d         = rd_req_q;
        busy_d           = busy_q;
        pass_d           = pass_q;
        fail_d           = fail_q;
        err_cnt_d        = err_cnt_q;
        first_err_addr_d = first_err_addr_q;
        timeout_d        = timeout_q;
        armed_d          = armed_q;
        wdog_d           = '0;
        wr_seed          = 1'b0;
        rd_seed          = 1'b0;
        chk_mis_d        = stray | (exp_step & (avl_rdata[CMP_W-1:0] != exp_pat[CMP_W-1:0]));
        chk_stray_d      = stray;
        chk_addr_d       = BASE_ADDR + ADDR_W'(rd_cnt_q);

        if (exp_step) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (chk_mis_q) begin
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
            if (err_cnt_q == 16'd0) begin
                first_err_addr_d = chk_addr_q;
            end
        end
        if (chk_stray_q) begin
            pass_d = 1'b0;
            fail_d = 1'b1;
        end
        if (active && !activity) begin
            wdog_d = wdog_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d          = ST_WAIT_RDY;
                    mode_d           = mode;
                    busy_d           = 1'b1;
                    pass_d           = 1'b0;
                    fail_d           = 1'b0;
                    timeout_d        = 1'b0;
                    err_cnt_d        = '0;
                    first_err_addr_d = '0;
                    rd_cnt_d         = '0;
                    req_idx_d        = '0;
                    armed_d          = 1'b1;
                    chk_mis_d        = 1'b0;
                    chk_stray_d      = 1'b0;
                end
            end
            ST_WAIT_RDY: begin
                if (ram_rdy) begin
                    state_d   = ST_WRITE;
                    wr_req_d  = 1'b1;
                    req_idx_d = '0;
                    wr_seed   = 1'b1;
                end
            end
            ST_WRITE, ST_READ, ST_DRAIN: begin
                if (!ram_rdy || (wdog_q == WD_LAST && !activity)) begin
                    state_d   = ST_IDLE;
                    wr_req_d  = 1'b0;
                    rd_req_d  = 1'b0;
                    busy_d    = 1'b0;
                    pass_d    = 1'b0;
                    fail_d    = 1'b1;
                    timeout_d = 1'b1;
                end else if (state_q == ST_WRITE) begin
                    if (wr_acc) begin
                        if (req_idx_q == LAST_IDX) begin
                            state_d   = ST_READ;
                            wr_req_d  = 1'b0;
                            rd_req_d  = 1'b1;
                            req_idx_d = '0;
                            rd_seed   = 1'b1;
                        end else begin
                            req_idx_d = req_idx_q + 1'b1;
                        end
                    end
                end else if (state_q == ST_READ) begin
                    if (rd_acc) begin
                        if (req_idx_q == LAST_IDX) begin
                            state_d  = ST_DRAIN;
                            rd_req_d = 1'b0;
                        end else begin
                            req_idx_d = req_idx_q + 1'b1;
                        end
                    end
                end else if (rd_cnt_q == FRAME_CNT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // The last compare has landed in err_cnt_q by now; chk_mis_q catches a late stray.
                pass_d  = (err_cnt_q == 16'd0) && !chk_mis_q && !fail_q;
                fail_d  = !((err_cnt_q == 16'd0) && !chk_mis_q && !fail_q);
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= ST_IDLE;
            mode_q           <= '0;
            req_idx_q        <= '0;
            rd_cnt_q         <= '0;
            wr_req_q         <= 1'b0;
            rd_req_q         <= 1'b0;
            busy_q           <= 1'b0;
            pass_q           <= 1'b0;
            fail_q           <= 1'b0;
            err_cnt_q        <= '0;
            first_err_addr_q <= '0;
            timeout_q        <= 1'b0;
            wdog_q           <= '0;
            armed_q          <= 1'b0;
            chk_mis_q        <= 1'b0;
            chk_stray_q      <= 1'b0;
            chk_addr_q       <= '0;
        end else begin
            state_q          <= state_d;
            mode_q           <= mode_d;
            req_idx_q        <= req_idx_d;
            rd_cnt_q         <= rd_cnt_d;
            wr_req_q         <= wr_req_d;
            rd_req_q         <= rd_req_d;
            busy_q           <= busy_d;
            pass_q           <= pass_d;
            fail_q           <= fail_d;
            err_cnt_q        <= err_cnt_d;
            first_err_addr_q <= first_err_addr_d;
            timeout_q        <= timeout_d;
            wdog_q           <= wdog_d;
            armed_q          <= armed_d;
            chk_mis_q        <= chk_mis_d;
            chk_stray_q      <= chk_stray_d;
            chk_addr_q       <= chk_addr_d;
        end
    end

    logic unused_hi;
    assign unused_hi = ^{avl_rdata[DATA_W-1:CMP_W], exp_pat[DATA_W-1:CMP_W]};

    assign avl_write_req  = wr_req_q;
    assign avl_read_req   = rd_req_q;
    assign avl_addr       = (wr_req_q | rd_req_q) ? (BASE_ADDR + ADDR_W'(req_idx_q)) : '0;
    assign avl_wdata      = wr_req_q ? wr_pat : '0;
    assign busy           = busy_q;
    assign pass           = pass_q;
    assign fail           = fail_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_err_addr_q;
    assign timeout        = timeout_q;

endmodule

// File: tb/tb_frame_mem_bist.sv
// tb/tb_frame_mem_bist.sv - directed bench for frame_mem_bist with a behavioural RAM port model
module tb_frame_mem_bist;

    localparam int          FP   = 16;
    localparam int          WD   = 64;
    localparam logic [28:0] BASE = 29'h0000_0100;
    localparam logic [31:0] PC   = 32'h00FF_FFFF;
    localparam logic [31:0] SEED = 32'hACE1_2468;

    logic        clk, reset, start, ram_rdy, avl_ready, avl_write_req, avl_read_req;
    logic [1:0]  mode;
    logic [28:0] avl_addr, first_err_addr;
    logic [31:0] avl_wdata, avl_rdata;
    logic        avl_rdata_valid, busy, pass, fail, timeout;
    logic [15:0] err_cnt;

    int vec = 0;
    int miss = 0;

    frame_mem_bist #(
        .FRAME_PIX(FP), .BASE_ADDR(BASE), .WDOG_CYC(WD)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .ram_rdy(ram_rdy),
        .avl_ready(avl_ready), .avl_write_req(avl_write_req), .avl_read_req(avl_read_req),
        .avl_addr(avl_addr), .avl_wdata(avl_wdata), .avl_rdata(avl_rdata),
        .avl_rdata_valid(avl_rdata_valid), .busy(busy), .pass(pass), .fail(fail),
        .err_cnt(err_cnt), .first_err_addr(first_err_addr), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: decisions at negedge take effect at the following posedge
    int          ready_mode = 0, lat_min = 1, lat_max = 1, cor_idx = -1, cor_bit = 0;
    int          n_wr = 0, n_rd = 0, cyc = 0, last_due = 0;
    logic [31:0] mem [FP];
    logic [31:0] first_wdata;
    logic [28:0] first_addr;
    bit          got_first = 0;
    logic [31:0] rq_data[$];
    int          rq_due[$];
    bit          prev_stall = 0, prev_wr, prev_rd;
    logic [28:0] prev_addr;
    logic [31:0] prev_wdata;

    always @(negedge clk) begin
        int idx;
        int due;
        logic [31:0] d;
        cyc++;
        if (prev_stall && busy && reset) begin
            vec++;
            if ({avl_write_req, avl_read_req, avl_addr, avl_wdata} !== {prev_wr, prev_rd, prev_addr, prev_wdata}) begin
                miss++;
                $display("FAIL hold_stable: got %b%b %h %h, want %b%b %h %h", avl_write_req, avl_read_req,
                         avl_addr, avl_wdata, prev_wr, prev_rd, prev_addr, prev_wdata);
            end
        end
        if (busy) begin
            vec++;
            if (avl_write_req && avl_read_req) begin
                miss++;
                $display("FAIL both_req: got wr=1 rd=1, want at most one");
            end
        end
        avl_rdata_valid = 1'b0;
        if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
            avl_rdata_valid = 1'b1;
            avl_rdata = rq_data.pop_front();
            void'(rq_due.pop_front());
        end
        case (ready_mode)
            0:       avl_ready = 1'b1;
            1:       avl_ready = 1'($urandom_range(0, 1));
            default: avl_ready = 1'b0;
        endcase
        if (reset && avl_ready && avl_write_req) begin
            idx = int'(avl_addr - BASE);
            if (idx < FP) mem[idx] = avl_wdata;
            if (!got_first) begin
                first_wdata = avl_wdata;
                first_addr  = avl_addr;
                got_first   = 1;
            end
            n_wr++;
        end
        if (reset && avl_ready && avl_read_req) begin
            idx = int'(avl_addr - BASE);
            d = (idx < FP) ? mem[idx] : 32'h0;
            if (idx == cor_idx) d = d ^ (32'd1 << cor_bit);
            due = cyc + int'($urandom_range(lat_min, lat_max));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            rq_data.push_back(d);
            rq_due.push_back(due);
            n_rd++;
        end
        prev_stall = (avl_write_req || avl_read_req) && !avl_ready;
        prev_wr    = avl_write_req;
        prev_rd    = avl_read_req;
        prev_addr  = avl_addr;
        prev_wdata = avl_wdata;
    end

    function automatic logic [31:0] ref_lfsr(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ ((32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1);
        return n;
    endfunction

    task automatic clear_model(input int rmode, input int lmin, input int lmax);
        for (int i = 0; i < FP; i++) mem[i] = 32'h0;
        n_wr = 0; n_rd = 0; got_first = 0; cor_idx = -1; cor_bit = 0;
        ready_mode = rmode; lat_min = lmin; lat_max = lmax;
    endtask

    task automatic pulse_start(input logic [1:0] m);
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok, output int n);
        ok = 0;
        n  = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            n++;
            if (!busy) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_req(input bit rd, input int max_cyc, output bit ok);
        ok = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if ((rd ? avl_read_req : avl_write_req) === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; mode = 2'd0; ram_rdy = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        vec++;
        if ({busy, pass, fail, timeout, avl_write_req, avl_read_req} !== 6'b0) begin
            miss++; $display("FAIL reset_flags: got %b, want 000000", {busy, pass, fail, timeout, avl_write_req, avl_read_req});
        end
        vec++;
        if ({err_cnt, first_err_addr, avl_addr, avl_wdata} !== '0) begin
            miss++; $display("FAIL reset_values: got %h %h %h %h, want all 0", err_cnt, first_err_addr, avl_addr, avl_wdata);
        end
        @(negedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic test_mode0;
        bit ok; int n;
        clear_model(0, 1, 1);
        pulse_start(2'd0);
        wait_idle(200, ok, n);
        vec++; if (!ok) begin miss++; $display("FAIL m0_done: got busy after 200 cycles, want idle"); end
        vec++; if ({pass, fail, timeout} !== 3'b100) begin miss++; $display("FAIL m0_result: got pfx=%b, want 100", {pass, fail, timeout}); end
        vec++; if (err_cnt !== 16'd0 || first_err_addr !== 29'd0) begin miss++; $display("FAIL m0_errs: got %0d %h, want 0 0", err_cnt, first_err_addr); end
        vec++; if (n_wr !== FP || n_rd !== FP) begin miss++; $display("FAIL m0_counts: got wr=%0d rd=%0d, want 16 16", n_wr, n_rd); end
        vec++; if (first_addr !== BASE || mem[0] !== PC || mem[15] !== PC) begin
            miss++; $display("FAIL m0_data: got %h %h %h, want %h %h %h", first_addr, mem[0], mem[15], BASE, PC, PC);
        end
        vec++; if (n < 30 || n > 40) begin miss++; $display("FAIL m0_latency: got %0d cycles, want 30..40", n); end
    endtask

    task automatic test_mode1_corrupt(input int bitpos, input bit expect_err);
        bit ok; int n;
        clear_model(0, 2, 2);
        cor_idx = 5; cor_bit = bitpos;
        pulse_start(2'd1);
        wait_idle(200, ok, n);
        vec++; if (!ok) begin miss++; $display("FAIL m1_done_b%0d: got busy, want idle", bitpos); end
        vec++; if (mem[7] !== 32'd7) begin miss++; $display("FAIL m1_pattern: got %h, want 00000007", mem[7]); end
        if (expect_err) begin
            vec++; if ({pass, fail, timeout} !== 3'b010) begin miss++; $display("FAIL m1_result: got pfx=%b, want 010", {pass, fail, timeout}); end
            vec++; if (err_cnt !== 16'd1) begin miss++; $display("FAIL m1_errcnt: got %0d, want 1", err_cnt); end
            vec++; if (first_err_addr !== BASE + 29'd5) begin miss++; $display("FAIL m1_first: got %h, want %h", first_err_addr, BASE + 29'd5); end
        end else begin
            vec++; if ({pass, fail, err_cnt} !== {2'b10, 16'd0}) begin
                miss++; $display("FAIL m1_upper_ignored: got p=%b f=%b cnt=%0d, want 1 0 0", pass, fail, err_cnt);
            end
        end
    endtask

    task automatic test_stall_mode2;
        bit ok; int n;
        clear_model(1, 1, 20);
        pulse_start(2'd2);
        wait_req(1'b0, 50, ok);
        pulse_start(2'd0);
        wait_idle(3000, ok, n);
        vec++; if (!ok) begin miss++; $display("FAIL stall_done: got busy after 3000 cycles, want idle"); end
        vec++; if ({pass, fail, err_cnt} !== {2'b10, 16'd0}) begin
            miss++; $display("FAIL stall_result: got p=%b f=%b cnt=%0d, want 1 0 0", pass, fail, err_cnt);
        end
        vec++; if (mem[3] !== 32'hFFFF_FFFC || n_wr !== FP || n_rd !== FP) begin
            miss++; $display("FAIL stall_data: got %h wr=%0d rd=%0d, want fffffffc 16 16", mem[3], n_wr, n_rd);
        end
    endtask

    task automatic test_lfsr;
        bit ok; int n;
        logic [31:0] w0, w1;
        clear_model(0, 1, 3);
        pulse_start(2'd3);
        wait_idle(200, ok, n);
`ifdef FRAME_BIST_LFSR_EN
        w0 = SEED;
        w1 = ref_lfsr(SEED);
`else
        w0 = PC;
        w1 = PC;
`endif
        vec++; if (first_wdata !== w0 || mem[1] !== w1) begin
            miss++; $display("FAIL lfsr_data: got %h %h, want %h %h", first_wdata, mem[1], w0, w1);
        end
        vec++; if (!ok || pass !== 1'b1 || err_cnt !== 16'd0) begin
            miss++; $display("FAIL lfsr_result: got ok=%b p=%b cnt=%0d, want 1 1 0", ok, pass, err_cnt);
        end
    endtask

    task automatic test_watchdog;
        bit ok; int n;
        clear_model(2, 1, 1);
        pulse_start(2'd0);
        wait_req(1'b0, 20, ok);
        n = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        vec++; if (!ok || n != WD) begin miss++; $display("FAIL wdog_cycles: got %0d, want %0d", n, WD); end
        vec++; if ({busy, pass, fail, timeout, avl_write_req} !== 5'b00110) begin
            miss++; $display("FAIL wdog_flags: got %b, want 00110", {busy, pass, fail, timeout, avl_write_req});
        end
        ready_mode = 0;
    endtask

    task automatic test_ram_rdy_drop;
        bit ok;
        clear_model(0, 3, 3);
        pulse_start(2'd1);
        wait_req(1'b1, 60, ok);
        repeat (2) @(negedge clk);
        ram_rdy = 1'b0;
        @(negedge clk);
        vec++; if (!ok || {avl_read_req, busy, timeout, fail, pass} !== 5'b00110) begin
            miss++; $display("FAIL rdy_drop: got ok=%b rd/busy/to/f/p=%b, want 00110", ok, {avl_read_req, busy, timeout, fail, pass});
        end
        ram_rdy = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    task automatic test_reset_mid(input bit in_read);
        bit ok;
        clear_model(0, 8, 8);
        pulse_start(2'd0);
        wait_req(in_read, 60, ok);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        vec++; if (!ok || {busy, pass, fail, timeout, avl_write_req, avl_read_req, err_cnt, first_err_addr, avl_addr, avl_wdata} !== '0) begin
            miss++; $display("FAIL reset_mid_%0d: got ok=%b busy=%b wr=%b rd=%b addr=%h, want 1 and all 0", in_read, ok, busy,
                             avl_write_req, avl_read_req, avl_addr);
        end
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (30) @(negedge clk);
        vec++; if ({busy, pass, fail, timeout, err_cnt} !== '0) begin
            miss++; $display("FAIL reset_quiet_%0d: got b/p/f/t=%b cnt=%0d, want 0000 0", in_read, {busy, pass, fail, timeout}, err_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_mode0;
        test_mode1_corrupt(3, 1'b1);
        test_mode1_corrupt(28, 1'b0);
        test_stall_mode2;
        test_lfsr;
        test_watchdog;
        test_ram_rdy_drop;
        test_reset_mid(1'b0);
        test_reset_mid(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
